// File: rtl/minibus_ram_slave_if.sv
// rtl/minibus_ram_slave_if.sv - minibus request/response signal bundle
interface minibus_ram_slave_if;
  logic        sel;
  logic [31:0] req_addr;
  logic        req_ren;
  logic        req_wen;
  logic [31:0] req_wdata;
  logic [3:0]  req_strobe;
  logic        res_ready;
  logic        res_error;
  logic [31:0] res_rdata;

  modport master (
    output sel, req_addr, req_ren, req_wen, req_wdata, req_strobe,
    input  res_ready, res_error, res_rdata
  );

  modport slave (
    input  sel, req_addr, req_ren, req_wen, req_wdata, req_strobe,
    output res_ready, res_error, res_rdata
  );
endinterface

// File: rtl/minibus_ram_slave.sv
// rtl/minibus_ram_slave.sv - word-organised RAM responder on the minibus
// Accepts one request, waits WAIT_CYCLES, then answers with a one-cycle ready pulse.
module minibus_ram_slave #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          DEPTH       = 1024,
  parameter int          WAIT_CYCLES = 1
) (
  input logic                 CLK,
  input logic                 nRST,
  minibus_ram_slave_if.slave  bus
);
  localparam int          AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [31:0] DEPTH_W = 32'(DEPTH);
  localparam logic [3:0]  WAIT_W  = WAIT_CYCLES[3:0];

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        ren_q;
  logic        wen_q;
  logic [3:0]  strobe_q;

  logic [31:0] mem [DEPTH];

  logic [31:0] offset;
  logic [31:0] index;
  logic [AW-1:0] mem_idx;
  logic        req_err;

  // Subtraction wraps, so addresses below BASE_ADDR land far out of range.
  assign offset  = addr_q - BASE_ADDR;
  assign index   = offset >> 2;
  assign mem_idx = index[AW-1:0];
  assign req_err = (addr_q[1:0] != 2'b00) || (index >= DEPTH_W) || (ren_q && wen_q);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state     <= IDLE;
      cnt       <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      ren_q     <= 1'b0;
      wen_q     <= 1'b0;
      strobe_q  <= '0;
      bus.res_ready <= 1'b0;
      bus.res_error <= 1'b0;
      bus.res_rdata <= '0;
    end else begin
      bus.res_ready <= 1'b0;
      bus.res_error <= 1'b0;
      bus.res_rdata <= '0;
      case (state)
        IDLE: begin
          if (bus.sel && (bus.req_ren || bus.req_wen)) begin
            addr_q   <= bus.req_addr;
            wdata_q  <= bus.req_wdata;
            ren_q    <= bus.req_ren;
            wen_q    <= bus.req_wen;
            strobe_q <= bus.req_strobe;
            cnt      <= WAIT_W;
            state    <= (WAIT_CYCLES > 0) ? WAIT : RESP;
          end
        end
        WAIT: begin
          if (!bus.sel) begin
            cnt   <= '0;
            state <= IDLE;
          end else if (cnt <= 4'd1) begin
            cnt   <= '0;
            state <= RESP;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          bus.res_ready <= 1'b1;
          bus.res_error <= req_err;
          bus.res_rdata <= (!req_err && ren_q) ? mem[mem_idx] : '0;
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Storage carries no reset; writes commit on the edge that leaves RESP.
  always_ff @(posedge CLK) begin
    if (state == RESP && wen_q && !req_err) begin
      for (int n = 0; n < 4; n++) begin
        if (strobe_q[n]) mem[mem_idx][8*n +: 8] <= wdata_q[8*n +: 8];
      end
    end
  end
endmodule

// File: tb/tb_minibus_ram_slave.sv
// tb/tb_minibus_ram_slave.sv - bench for minibus_ram_slave at four wait-state settings
module tb_minibus_ram_slave;
  localparam logic [31:0] BASE  = 32'h0000_0000;
  localparam int          DEPTH = 1024;

  logic CLK = 1'b0;
  logic nRST = 1'b0;
  always #5 CLK = ~CLK;

  logic [3:0]  sel_v  = '0;
  logic [31:0] addr   = '0;
  logic        ren    = 1'b0;
  logic        wen    = 1'b0;
  logic [31:0] wdata  = '0;
  logic [3:0]  strobe = '0;

  logic [3:0]  ready_v;
  logic [3:0]  error_v;
  logic [31:0] rdata_v [4];

  int wc [4] = '{1, 0, 5, 3};
  logic [31:0] model [4][DEPTH];
  int checks = 0;
  int errors = 0;

  minibus_ram_slave_if bus [4] ();

  for (genvar g = 0; g < 4; g++) begin : g_dut
    assign bus[g].sel        = sel_v[g];
    assign bus[g].req_addr   = addr;
    assign bus[g].req_ren    = ren;
    assign bus[g].req_wen    = wen;
    assign bus[g].req_wdata  = wdata;
    assign bus[g].req_strobe = strobe;
    assign ready_v[g] = bus[g].res_ready;
    assign error_v[g] = bus[g].res_error;
    assign rdata_v[g] = bus[g].res_rdata;

    minibus_ram_slave #(
      .BASE_ADDR  (BASE),
      .DEPTH      (DEPTH),
      .WAIT_CYCLES((g == 0) ? 1 : (g == 1) ? 0 : (g == 2) ? 5 : 3)
    ) dut (
      .CLK (CLK),
      .nRST(nRST),
      .bus (bus[g])
    );
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Runs one full transaction on DUT k and checks latency, pulse width and payload against the model.
  task automatic txn(input int k, input logic [31:0] a, input logic r, input logic w,
                     input logic [31:0] wd, input logic [3:0] st,
                     output logic [31:0] rd, output logic er);
    int n;
    logic [31:0] idx;
    logic exp_err;
    logic [31:0] exp_rd;
    idx     = (a - BASE) >> 2;
    exp_err = (a[1:0] != 2'b00) || (idx >= DEPTH) || (r && w);
    exp_rd  = (!exp_err && r) ? model[k][idx[9:0]] : 32'h0;
    addr = a; ren = r; wen = w; wdata = wd; strobe = st;
    sel_v = 4'b0001 << k;
    @(posedge CLK); #1;
    n = 0;
    do begin
      @(posedge CLK); #1;
      n++;
    end while (ready_v[k] !== 1'b1 && n < 40);
    rd = rdata_v[k];
    er = error_v[k];
    sel_v = '0; ren = 1'b0; wen = 1'b0;
    check($sformatf("latency_dut%0d", k), 32'(n), 32'(wc[k] + 1));
    check($sformatf("error_dut%0d_a%h", k, a), {31'b0, er}, {31'b0, exp_err});
    check($sformatf("rdata_dut%0d_a%h", k, a), rd, exp_rd);
    @(posedge CLK); #1;
    check($sformatf("pulse_ready_dut%0d", k), {31'b0, ready_v[k]}, 32'h0);
    check($sformatf("idle_rdata_dut%0d", k), rdata_v[k] | {31'b0, error_v[k]}, 32'h0);
    if (!exp_err && w) begin
      for (int b = 0; b < 4; b++) if (st[b]) model[k][idx[9:0]][8*b +: 8] = wd[8*b +: 8];
    end
  endtask

  initial begin
    logic [31:0] rd;
    logic er;
    logic seen;
    for (int k = 0; k < 4; k++) for (int i = 0; i < DEPTH; i++) model[k][i] = 32'h0;

    repeat (2) @(posedge CLK);
    #1;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("reset_out_dut%0d", k),
            {rdata_v[k][31:2], ready_v[k], error_v[k]} | rdata_v[k], 32'h0);
    end
    nRST = 1'b1;
    @(posedge CLK); #1;

    // Basic write/read and byte strobes with one wait state.
    txn(0, 32'h8, 1'b0, 1'b1, 32'hDEADBEEF, 4'hF, rd, er);
    txn(0, 32'h8, 1'b1, 1'b0, 32'h0, 4'h0, rd, er);
    check("read_deadbeef", rd, 32'hDEADBEEF);
    txn(0, 32'h8, 1'b0, 1'b1, 32'h11223344, 4'b0101, rd, er);
    txn(0, 32'h8, 1'b1, 1'b0, 32'h0, 4'h0, rd, er);
    check("read_strobed", rd, 32'hDE22BE44);
    txn(0, 32'h8, 1'b0, 1'b1, 32'hFFFFFFFF, 4'h0, rd, er);
    txn(0, 32'h8, 1'b1, 1'b0, 32'h0, 4'h0, rd, er);
    check("zero_strobe_noop", rd, 32'hDE22BE44);

    // Error cases and the last valid word.
    txn(0, BASE + 32'h1000, 1'b1, 1'b0, 32'h0, 4'h0, rd, er);
    check("oor_error", {31'b0, er}, 32'h1);
    txn(0, 32'h6, 1'b1, 1'b0, 32'h0, 4'h0, rd, er);
    check("misaligned_error", {31'b0, er}, 32'h1);
    txn(0, 32'h0, 1'b0, 1'b1, 32'h12345678, 4'hF, rd, er);
    txn(0, 32'h0, 1'b1, 1'b1, 32'hFFFFFFFF, 4'hF, rd, er);
    check("renwen_error", {31'b0, er}, 32'h1);
    txn(0, 32'h0, 1'b1, 1'b0, 32'h0, 4'h0, rd, er);
    check("renwen_mem_kept", rd, 32'h12345678);
    txn(0, 32'hFFC, 1'b0, 1'b1, 32'hA1B2C3D4, 4'hF, rd, er);
    txn(0, 32'hFFC, 1'b1, 1'b0, 32'h0, 4'h0, rd, er);
    check("last_word", rd, 32'hA1B2C3D4);

    // Zero and five wait states.
    txn(1, 32'h4, 1'b0, 1'b1, 32'h0F0F0F0F, 4'hF, rd, er);
    txn(1, 32'h4, 1'b1, 1'b0, 32'h0, 4'h0, rd, er);
    check("w0_read", rd, 32'h0F0F0F0F);
    txn(2, 32'h4, 1'b0, 1'b1, 32'h76543210, 4'hF, rd, er);
    txn(2, 32'h4, 1'b1, 1'b0, 32'h0, 4'h0, rd, er);
    check("w5_read", rd, 32'h76543210);

    // Abort: drop sel in the second wait cycle of a three-wait write.
    txn(3, 32'h10, 1'b0, 1'b1, 32'hCAFE0001, 4'hF, rd, er);
    addr = 32'h10; ren = 1'b0; wen = 1'b1; wdata = 32'h55; strobe = 4'hF; sel_v = 4'b1000;
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    sel_v = '0; wen = 1'b0;
    seen = 1'b0;
    repeat (8) begin
      @(posedge CLK); #1;
      if (ready_v[3] !== 1'b0) seen = 1'b1;
    end
    check("abort_no_ready", {31'b0, seen}, 32'h0);
    txn(3, 32'h10, 1'b1, 1'b0, 32'h0, 4'h0, rd, er);
    check("abort_old_value", rd, 32'hCAFE0001);

    // Reset in the middle of a wait.
    txn(2, 32'h20, 1'b0, 1'b1, 32'h0BADF00D, 4'hF, rd, er);
    addr = 32'h20; ren = 1'b0; wen = 1'b1; wdata = 32'hA5A5A5A5; strobe = 4'hF; sel_v = 4'b0100;
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    nRST = 1'b0;
    #1;
    sel_v = '0; wen = 1'b0;
    #1 nRST = 1'b1;
    seen = 1'b0;
    repeat (10) begin
      @(posedge CLK); #1;
      if (ready_v[2] !== 1'b0) seen = 1'b1;
    end
    check("reset_no_ready", {31'b0, seen}, 32'h0);
    txn(2, 32'h20, 1'b1, 1'b0, 32'h0, 4'h0, rd, er);
    check("reset_no_write", rd, 32'h0BADF00D);

    // Reset while a read response is on the bus clears it before the next edge.
    addr = 32'h8; ren = 1'b1; wen = 1'b0; sel_v = 4'b0001;
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    check("pre_reset_ready", {31'b0, ready_v[0]}, 32'h1);
    sel_v = '0; ren = 1'b0;
    nRST = 1'b0;
    #1;
    check("async_reset_ready", {31'b0, ready_v[0]}, 32'h0);
    check("async_reset_rdata", rdata_v[0], 32'h0);
    #1 nRST = 1'b1;
    @(posedge CLK); #1;

    // Randomised traffic against the reference model.
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 16; i++) txn(k, 32'(i * 4), 1'b0, 1'b1, $urandom, 4'hF, rd, er);
      for (int t = 0; t < 30; t++) begin
        int kind;
        logic [31:0] a;
        kind = $urandom_range(0, 9);
        a = 32'($urandom_range(0, 15) * 4);
        case (kind)
          0: txn(k, a | 32'($urandom_range(1, 3)), 1'b1, 1'b0, 32'h0, 4'h0, rd, er);
          1: txn(k, 32'h1000 + 32'($urandom_range(0, 4000) * 4), 1'b0, 1'b1, $urandom, 4'hF, rd, er);
          2: txn(k, a, 1'b1, 1'b1, $urandom, 4'hF, rd, er);
          3, 4, 5: txn(k, a, 1'b0, 1'b1, $urandom, 4'($urandom_range(0, 15)), rd, er);
          default: txn(k, a, 1'b1, 1'b0, 32'h0, 4'h0, rd, er);
        endcase
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
